attr_stepper: RTL

Downstream consumer of the plane-equation coefficient generator in the GPU triangle path. It takes one primitive's attribute coefficients (cx, cy, cs) plus a screen bounding box. It walks the box in raster order and emits one interpolated attribute value per pixel over a valid/ready stream. Evaluation is incremental: one setup evaluation per primitive, then one add per pixel. The result feeds the pixel/shade stage.

---
 rtl/gpu_attr_pkg.sv | 27 ++
 rtl/attr_clamp.sv | 27 ++
 rtl/attr_stepper.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/gpu_attr_pkg.sv
// Shared types and constants for the triangle attribute stepping path.
// Coefficients are s(x,y) = cx*x + cy*y + cs in two's-complement with FRAC_BITS fraction bits.
package gpu_attr_pkg;

    localparam int FRAC_BITS = 6;
    localparam int ACC_W     = 40;
    localparam int OUT_W     = 12;
    localparam int COEF_W    = 24;
    localparam int CRD_W     = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WALK  = 2'd2
    } state_e;

    typedef struct packed {
        logic signed [COEF_W-1:0] cx;
        logic signed [COEF_W-1:0] cy;
        logic signed [COEF_W-1:0] cs;
        logic [CRD_W-1:0]         xmin;
        logic [CRD_W-1:0]         xmax;
        logic [CRD_W-1:0]         ymin;
        logic [CRD_W-1:0]         ymax;
    } desc_t;

endpackage

// File: rtl/attr_clamp.sv
// Converts a fixed-point accumulator to an unsigned attribute: arithmetic shift (floor), then saturate.
// Purely combinational; no latency, no flow control.
module attr_clamp #(
    parameter int IN_W   = gpu_attr_pkg::ACC_W,
    parameter int FRAC_W = gpu_attr_pkg::FRAC_BITS,
    parameter int OUT_W  = gpu_attr_pkg::OUT_W
) (
    input  logic signed [IN_W-1:0] acc_i,
    output logic [OUT_W-1:0]       s_o
);

    localparam logic signed [IN_W-1:0] SAT = IN_W'((1 << OUT_W) - 1);

    logic signed [IN_W-1:0] sh;

    assign sh = acc_i >>> FRAC_W;

    always_comb begin
        s_o = sh[OUT_W-1:0];
        if (sh[IN_W-1]) begin
            s_o = '0;
        end else if (sh > SAT) begin
            s_o = '1;
        end
    end

endmodule

// File: rtl/attr_stepper.sv
// Walks a bounding box in raster order emitting one plane-interpolated attribute per pixel.
// Accept -> 1 setup cycle -> 1 pixel/clock; out_ready low freezes all state until the handshake.
module attr_stepper #(
    parameter int FRAC_BITS = gpu_attr_pkg::FRAC_BITS,
    parameter int ACC_W     = gpu_attr_pkg::ACC_W,
    parameter int OUT_W     = gpu_attr_pkg::OUT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [23:0] cx,
    input  logic signed [23:0] cy,
    input  logic signed [23:0] cs,
    input  logic [11:0]        xmin,
    input  logic [11:0]        xmax,
    input  logic [11:0]        ymin,
    input  logic [11:0]        ymax,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [11:0]        out_x,
    output logic [11:0]        out_y,
    output logic [OUT_W-1:0]   out_s,
    output logic               out_last,
    output logic               done
);

    import gpu_attr_pkg::*;

    state_e                  state_q, state_d;
    desc_t                   desc_q, desc_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] row_q, row_d;
    logic [11:0]             x_q, x_d;
    logic [11:0]             y_q, y_d;
    logic                    done_q, done_d;

    logic signed [ACC_W-1:0] cx_ext, cy_ext, cs_ext, xmin_ext, ymin_ext, base;
    logic                    at_xmax, at_ymax;

    // Coordinates are unsigned, so they enter the signed products zero-extended.
    assign cx_ext   = {{(ACC_W-24){desc_q.cx[23]}}, desc_q.cx};
    assign cy_ext   = {{(ACC_W-24){desc_q.cy[23]}}, desc_q.cy};
    assign cs_ext   = {{(ACC_W-24){desc_q.cs[23]}}, desc_q.cs};
    assign xmin_ext = {{(ACC_W-12){1'b0}}, desc_q.xmin};
    assign ymin_ext = {{(ACC_W-12){1'b0}}, desc_q.ymin};
    assign base     = cx_ext * xmin_ext + cy_ext * ymin_ext + cs_ext;

    assign at_xmax = (x_q == desc_q.xmax);
    assign at_ymax = (y_q == desc_q.ymax);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            desc_q  <= '0;
            acc_q   <= '0;
            row_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            desc_q  <= desc_d;
            acc_q   <= acc_d;
            row_q   <= row_d;
            x_q     <= x_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        desc_d  = desc_q;
        acc_d   = acc_q;
        row_d   = row_q;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    desc_d.cx   = cx;
                    desc_d.cy   = cy;
                    desc_d.cs   = cs;
                    desc_d.xmin = xmin;
                    desc_d.xmax = xmax;
                    desc_d.ymin = ymin;
                    desc_d.ymax = ymax;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                acc_d = base;
                row_d = base;
                x_d   = desc_q.xmin;
                y_d   = desc_q.ymin;
                if (desc_q.xmax < desc_q.xmin || desc_q.ymax < desc_q.ymin) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = WALK;
                end
            end
            WALK: begin
                if (out_ready) begin
                    if (!at_xmax) begin
                        x_d   = x_q + 12'd1;
                        acc_d = acc_q + cx_ext;
                    end else if (!at_ymax) begin
                        // Next row restarts from the row base rather than unwinding the x steps.
                        x_d   = desc_q.xmin;
                        y_d   = y_q + 12'd1;
                        row_d = row_q + cy_ext;
                        acc_d = row_q + cy_ext;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    attr_clamp #(
        .IN_W   (ACC_W),
        .FRAC_W (FRAC_BITS),
        .OUT_W  (OUT_W)
    ) u_clamp (
        .acc_i (acc_q),
        .s_o   (out_s)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == WALK);
    assign out_last  = (state_q == WALK) && at_xmax && at_ymax;
    assign out_x     = x_q;
    assign out_y     = y_q;
    assign done      = done_q;

endmodule
